reg_mem_sram_adapter: RTL and testbench
=======================================

// Module: reg_mem_sram_adapter
// PURPOSE
//   Memory-side terminator for the register native-if-to-memory bridge, in the mem clock domain.
//   Accepts the level request bundle (req_vld/addr/wr_en/rd_en/wr_data, held until ack).
//   Drives a single-port synchronous SRAM with fixed read latency.
//   Returns one-cycle ack/err/rd_data pulses, safe to feed the per-bit pulse CDC path.
// PARAMETERS
//   MEM_DATA_WIDTH  64  data word width
//   MEM_ADDR_WIDTH  5   word address width
//   SRAM_DEPTH      32  implemented words; must be <= 2**MEM_ADDR_WIDTH
//   RD_LATENCY      1   SRAM clocks from sram_ce (read) to valid sram_rdata; >= 1
//   localparam SRAM_WIDTH = MEM_DATA_WIDTH (+1 if REG_MEM_SRAM_PARITY_EN)
// PORTS
//   clk          in   1               mem clock
//   rst_n        in   1               async active-low reset
//   mem_req_vld  in   1               request valid, level, held with fields until ack
//   mem_addr     in   MEM_ADDR_WIDTH  word address
//   mem_wr_en    in   1               write request
//   mem_rd_en    in   1               read request
//   mem_wr_data  in   MEM_DATA_WIDTH  write data
//   mem_ack_vld  out  1               completion pulse, exactly 1 cycle per request
//   mem_err      out  1               error, valid only with ack, else 0
//   mem_rd_data  out  MEM_DATA_WIDTH  read data, valid only with read ack, else all-0
//   sram_ce      out  1               SRAM chip enable, 1-cycle pulse
//   sram_we      out  1               SRAM write enable, qualified by sram_ce
//   sram_addr    out  MEM_ADDR_WIDTH  SRAM address
//   sram_wdata   out  SRAM_WIDTH      SRAM write word
//   sram_rdata   in   SRAM_WIDTH      SRAM read word
// BEHAVIOUR
//   - Interface: one clock (clk); reset asynchronous, active-low (rst_n).
//   - Reset: all outputs 0, FSM = IDLE, latency counter 0. In-flight SRAM read discarded; no ack issued.
//   - All outputs registered; no combinational input->output path.
//   - FSM states: IDLE, ISSUE, WAIT, ACK, GAP.
//   - IDLE: when mem_req_vld=1, capture addr/wr_en/rd_en/wr_data (cycle T) and decode:
//       - error if addr >= SRAM_DEPTH, or wr_en==rd_en (both set or neither) -> ACK with err=1, no SRAM access.
//       - otherwise -> ISSUE.
//   - ISSUE (T+1): sram_ce=1, sram_we=wr_en, sram_addr/sram_wdata from the captured values.
//       - write -> ACK
//       - read  -> WAIT, counter loaded with RD_LATENCY-1
//   - WAIT: decrement the counter. When the counter is 0, capture sram_rdata into the rd_data register -> ACK.
//   - ACK: mem_ack_vld=1 for exactly one cycle, with mem_err and mem_rd_data valid -> GAP.
//       - Latency from accept: write ack at T+2; read ack at T+2+RD_LATENCY; decode error ack at T+1.
//   - GAP: one turnaround cycle. mem_req_vld is ignored, since the upstream clears it the cycle after ack. -> IDLE.
//   - Outside the ack cycle: mem_err=0 and mem_rd_data=0, required by the pulse CDC. Writes ack with rd_data=0.
//   - Request-field changes while not IDLE are ignored; captured values are used throughout.
//   - mem_req_vld dropping before ack does not abort the transaction; ack is still issued.
//   - sram_we/sram_addr/sram_wdata return to 0 when sram_ce=0.
// CONFIGURATION
//   REG_MEM_SRAM_PARITY_EN defined:
//     - SRAM_WIDTH = MEM_DATA_WIDTH+1; sram_wdata[MSB] = ^wr_data (even parity).
//     - On read completion, parity mismatch -> mem_err=1 with ack; mem_rd_data still returns the data bits.
//   Undefined:
//     - SRAM_WIDTH = MEM_DATA_WIDTH; no parity bit; mem_err comes only from decode errors.
// TESTING
//   1. Reset released, no request -> all outputs 0 for 20 cycles.
//   2. Write addr=3, data=64'hA5A5_0000_FFFF_1234, then read addr=3, RD_LATENCY=1:
//        write ack at T+2 (err=0, rd_data=0); read ack at T+3 with that data.
//   3. Read addr=40 (SRAM_DEPTH=32) -> ack at T+1, err=1, rd_data=0, sram_ce never asserted.
//        Same response for wr_en=rd_en=1.
//   4. Back-to-back: req held 1 across ack -> GAP ignores it; second request accepted no earlier than ack+2.
//        Exactly one ack per request.
//   5. rst_n pulled low during WAIT with RD_LATENCY=3 -> outputs 0 immediately, no ack after release.
//        Next request completes normally.
//   6. PARITY_EN: backdoor-flip SRAM bit 0 at addr 7, read 7 -> ack with err=1; unflipped read -> err=0.

Source files
------------

// File: rtl/reg_mem_sram_adapter.sv
// reg_mem_sram_adapter: memory-side terminator of the register bridge.
// Turns a level request bundle (held until ack) into one single-port SRAM
// access and answers with one-cycle ack/err/rd_data pulses that can feed a
// per-bit pulse CDC. Out-of-range addresses and ambiguous requests (wr_en ==
// rd_en) are answered with an error and never reach the SRAM.
// Optional feature: define REG_MEM_SRAM_PARITY_EN to store an even-parity bit
// above the data word and flag parity mismatches on read completion.
module reg_mem_sram_adapter #(
   parameter int MEM_DATA_WIDTH = 64,
   parameter int MEM_ADDR_WIDTH = 5,
   parameter int SRAM_DEPTH     = 32,
   parameter int RD_LATENCY     = 1,
`ifdef REG_MEM_SRAM_PARITY_EN
   localparam int SRAM_WIDTH    = MEM_DATA_WIDTH + 1
`else
   localparam int SRAM_WIDTH    = MEM_DATA_WIDTH
`endif
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_req_vld,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   input  logic                      mem_wr_en,
   input  logic                      mem_rd_en,
   input  logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
   output logic                      mem_ack_vld,
   output logic                      mem_err,
   output logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
   output logic                      sram_ce,
   output logic                      sram_we,
   output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_WIDTH-1:0]     sram_wdata,
   input  logic [SRAM_WIDTH-1:0]     sram_rdata
);

   localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ACK,
      S_GAP
   } state_t;

   state_t           state;
   logic             is_read;
   logic [CNT_W-1:0] lat_cnt;
   logic             dec_err;

   // Build the stored SRAM word from a data word (parity bit on top when enabled)
   function automatic logic [SRAM_WIDTH-1:0] sram_word(input logic [MEM_DATA_WIDTH-1:0] d);
`ifdef REG_MEM_SRAM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

`ifdef REG_MEM_SRAM_PARITY_EN
   // Even parity over data plus parity bit must be zero for an intact word
   function automatic logic rd_parity_err(input logic [SRAM_WIDTH-1:0] w);
      return ^w;
   endfunction
`endif

   // Decode the live request: out-of-range address or not exactly one of wr/rd
   always_comb begin
      dec_err = (32'(mem_addr) >= SRAM_DEPTH) || (mem_wr_en == mem_rd_en);
   end

   // Request FSM; every output is a register, pulses default back to 0 each cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         is_read     <= 1'b0;
         lat_cnt     <= '0;
         mem_ack_vld <= 1'b0;
         mem_err     <= 1'b0;
         mem_rd_data <= '0;
         sram_ce     <= 1'b0;
         sram_we     <= 1'b0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
      end else begin
         mem_ack_vld <= 1'b0;
         mem_err     <= 1'b0;
         mem_rd_data <= '0;
         sram_ce     <= 1'b0;
         sram_we     <= 1'b0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         case (state)
            S_IDLE: begin
               if (mem_req_vld) begin
                  is_read <= mem_rd_en;
                  if (dec_err) begin
                     mem_ack_vld <= 1'b1;
                     mem_err     <= 1'b1;
                     state       <= S_ACK;
                  end else begin
                     // Request fields are captured straight into the SRAM
                     // command registers, so later input changes are ignored
                     sram_ce    <= 1'b1;
                     sram_we    <= mem_wr_en;
                     sram_addr  <= mem_addr;
                     sram_wdata <= mem_wr_en ? sram_word(mem_wr_data) : '0;
                     state      <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (is_read) begin
                  lat_cnt <= CNT_W'(RD_LATENCY - 1);
                  state   <= S_WAIT;
               end else begin
                  mem_ack_vld <= 1'b1;
                  state       <= S_ACK;
               end
            end
            S_WAIT: begin
               if (lat_cnt == '0) begin
                  mem_ack_vld <= 1'b1;
                  mem_rd_data <= sram_rdata[MEM_DATA_WIDTH-1:0];
`ifdef REG_MEM_SRAM_PARITY_EN
                  mem_err     <= rd_parity_err(sram_rdata);
`else
                  mem_err     <= 1'b0;
`endif
                  state       <= S_ACK;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            S_ACK: begin
               state <= S_GAP;
            end
            S_GAP: begin
               // Upstream is still clearing its request here; do not re-accept
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_mem_sram_adapter.sv
// Directed bench for reg_mem_sram_adapter: one instance at read latency 1 and
// one at read latency 3, each backed by a behavioural single-port SRAM.
module tb_reg_mem_sram_adapter;

   localparam int DW = 64;
   localparam int AW = 6;
`ifdef REG_MEM_SRAM_PARITY_EN
   localparam int SW = DW + 1;
`else
   localparam int SW = DW;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          req1 = 1'b0, wr1 = 1'b0, rd1 = 1'b0;
   logic [AW-1:0] addr1 = '0;
   logic [DW-1:0] wd1 = '0;
   logic          ack1, err1, ce1, we1;
   logic [DW-1:0] rdd1;
   logic [AW-1:0] sa1;
   logic [SW-1:0] swd1, srd1;

   logic          req3 = 1'b0, wr3 = 1'b0, rd3 = 1'b0;
   logic [AW-1:0] addr3 = '0;
   logic [DW-1:0] wd3 = '0;
   logic          ack3, err3, ce3, we3;
   logic [DW-1:0] rdd3;
   logic [AW-1:0] sa3;
   logic [SW-1:0] swd3, srd3;

   logic [SW-1:0] mem1 [64];
   logic [SW-1:0] mem3 [64];
   logic [SW-1:0] pipe1;
   logic [SW-1:0] pipe3 [3];
   logic          flip_req = 1'b0;

   int n_vec = 0;
   int n_miscmp = 0;
   int acks1 = 0, acks3 = 0;
   int exp_acks1 = 0, exp_acks3 = 0;

   always #5 clk = ~clk;

   reg_mem_sram_adapter #(
      .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_DEPTH(32), .RD_LATENCY(1)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req_vld(req1), .mem_addr(addr1), .mem_wr_en(wr1), .mem_rd_en(rd1),
      .mem_wr_data(wd1), .mem_ack_vld(ack1), .mem_err(err1), .mem_rd_data(rdd1),
      .sram_ce(ce1), .sram_we(we1), .sram_addr(sa1), .sram_wdata(swd1), .sram_rdata(srd1)
   );

   reg_mem_sram_adapter #(
      .MEM_DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SRAM_DEPTH(32), .RD_LATENCY(3)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .mem_req_vld(req3), .mem_addr(addr3), .mem_wr_en(wr3), .mem_rd_en(rd3),
      .mem_wr_data(wd3), .mem_ack_vld(ack3), .mem_err(err3), .mem_rd_data(rdd3),
      .sram_ce(ce3), .sram_we(we3), .sram_addr(sa3), .sram_wdata(swd3), .sram_rdata(srd3)
   );

   function automatic logic [DW-1:0] init_data(input int i);
      return {32'(i) + 32'hA000_0000, ~32'(i)};
   endfunction

   function automatic logic [SW-1:0] init_word(input int i);
      logic [DW-1:0] d;
      d = init_data(i);
`ifdef REG_MEM_SRAM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   // Behavioural SRAMs: loaded while reset is low, fixed read latency 1 and 3
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) begin
            mem1[i] <= init_word(i);
            mem3[i] <= init_word(i);
         end
      end else begin
         if (flip_req) mem1[7][0] <= ~mem1[7][0];
         if (ce1) begin
            if (we1) mem1[sa1] <= swd1;
            else     pipe1     <= mem1[sa1];
         end
         if (ce3) begin
            if (we3) mem3[sa3] <= swd3;
            else     pipe3[0]  <= mem3[sa3];
         end
      end
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end

   assign srd1 = pipe1;
   assign srd3 = pipe3[2];

   always @(negedge clk) begin
      if (ack1) acks1++;
      if (ack3) acks3++;
   end

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request on DUT sel (0: latency 1, 1: latency 3); latency counted in
   // cycles after the accept edge, ack expected in cycle exp_lat
   task automatic xact(input string tag, input bit sel, input logic [AW-1:0] a,
                       input logic w, input logic r, input logic [DW-1:0] d,
                       input int exp_lat, input logic exp_err, input logic [DW-1:0] exp_rd,
                       input bit hold);
      int lat, ce_cnt;
      bit idle_bad;
      logic e;
      logic [DW-1:0] q;
      @(negedge clk);
      if (sel) begin req3 = 1'b1; addr3 = a; wr3 = w; rd3 = r; wd3 = d; exp_acks3++; end
      else     begin req1 = 1'b1; addr1 = a; wr1 = w; rd1 = r; wd1 = d; exp_acks1++; end
      @(posedge clk);
      lat = 0; ce_cnt = 0; idle_bad = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (sel ? ce3 : ce1) ce_cnt++;
         else if ((sel ? {we3, sa3, swd3} : {we1, sa1, swd1}) != '0) idle_bad = 1'b1;
         if (sel ? ack3 : ack1) begin
            lat = n;
            e = sel ? err3 : err1;
            q = sel ? rdd3 : rdd1;
            check_vec({tag, "_err"}, 64'(e), 64'(exp_err));
            check_vec({tag, "_rdata"}, q, exp_rd);
            break;
         end
      end
      check_vec({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_vec({tag, "_ce_pulses"}, 64'(ce_cnt), (exp_lat > 1) ? 64'd1 : 64'd0);
      check_vec({tag, "_sram_idle_zero"}, 64'(idle_bad), 64'd0);
      if (!hold) begin
         if (sel) req3 = 1'b0; else req1 = 1'b0;
      end
      @(negedge clk);
      check_vec({tag, "_gap_quiet"},
                sel ? 64'({ack3, err3, |rdd3}) : 64'({ack1, err1, |rdd1}), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit busy;
      repeat (3) @(negedge clk);
      check_vec("reset_outputs", 64'(|{ack1, err1, rdd1, ce1, we1, sa1, swd1,
                                       ack3, err3, rdd3, ce3, we3, sa3, swd3}), 64'd0);
      rst_n = 1'b1;

      // Idle after reset: nothing moves for 20 cycles
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_vec("idle_outputs", 64'(|{ack1, err1, rdd1, ce1, we1, sa1, swd1,
                                         ack3, err3, rdd3, ce3, we3, sa3, swd3}), 64'd0);
      end

      // Write then read back, latency 1
      xact("wr3", 0, 6'd3, 1'b1, 1'b0, 64'hA5A5_0000_FFFF_1234, 2, 1'b0, 64'h0, 1'b0);
      xact("rd3", 0, 6'd3, 1'b0, 1'b1, 64'h0, 3, 1'b0, 64'hA5A5_0000_FFFF_1234, 1'b0);
      xact("rd_init12", 0, 6'd12, 1'b0, 1'b1, 64'hDEAD, 3, 1'b0, init_data(12), 1'b0);
      xact("wr31", 0, 6'd31, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 64'h0, 1'b0);
      xact("rd31", 0, 6'd31, 1'b0, 1'b1, 64'h0, 3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

      // Decode errors: out of range, both enables, neither enable
      xact("rd_addr40", 0, 6'd40, 1'b0, 1'b1, 64'h0, 1, 1'b1, 64'h0, 1'b0);
      xact("wr_addr32", 0, 6'd32, 1'b1, 1'b0, 64'hFFFF, 1, 1'b1, 64'h0, 1'b0);
      xact("wr_rd_both", 0, 6'd3, 1'b1, 1'b1, 64'h1111, 1, 1'b1, 64'h0, 1'b0);
      xact("wr_rd_none", 0, 6'd3, 1'b0, 1'b0, 64'h2222, 1, 1'b1, 64'h0, 1'b0);
      xact("rd3_after_err", 0, 6'd3, 1'b0, 1'b1, 64'h0, 3, 1'b0, 64'hA5A5_0000_FFFF_1234, 1'b0);

      // Back-to-back with request held through ack and GAP
      xact("b2b_wr", 0, 6'd5, 1'b1, 1'b0, 64'hCAFE_F00D_0000_0005, 2, 1'b0, 64'h0, 1'b1);
      xact("b2b_rd", 0, 6'd5, 1'b0, 1'b1, 64'h0, 3, 1'b0, 64'hCAFE_F00D_0000_0005, 1'b0);
      check_vec("ack_count_lat1", 64'(acks1), 64'(exp_acks1));

      // Latency-3 instance: normal read first
      xact("lat3_rd", 1, 6'd9, 1'b0, 1'b1, 64'h0, 5, 1'b0, init_data(9), 1'b0);

      // Reset in the middle of a latency-3 read
      @(negedge clk);
      req3 = 1'b1; addr3 = 6'd2; wr3 = 1'b0; rd3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_vec("rst_in_wait_outputs", 64'(|{ack3, err3, rdd3, ce3, we3, sa3, swd3}), 64'd0);
      req3 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack3 || ce3) busy = 1'b1;
      end
      check_vec("no_ack_after_reset", 64'(busy), 64'd0);
      check_vec("ack_count_lat3", 64'(acks3), 64'(exp_acks3));
      xact("lat3_after_rst", 1, 6'd2, 1'b0, 1'b1, 64'h0, 5, 1'b0, init_data(2), 1'b0);
      xact("lat3_wr", 1, 6'd4, 1'b1, 1'b0, 64'h7777_0000_1111_2222, 2, 1'b0, 64'h0, 1'b0);
      xact("lat3_rd4", 1, 6'd4, 1'b0, 1'b1, 64'h0, 5, 1'b0, 64'h7777_0000_1111_2222, 1'b0);

`ifdef REG_MEM_SRAM_PARITY_EN
      // Stored parity bit, then a corrupted word and the restored word
      xact("par_wr9", 0, 6'd9, 1'b1, 1'b0, 64'h0000_0000_0000_0007, 2, 1'b0, 64'h0, 1'b0);
      check_vec("par_bit9", 64'(mem1[9][DW]), 64'd1);
      @(negedge clk); flip_req = 1'b1;
      @(negedge clk); flip_req = 1'b0;
      xact("par_bad7", 0, 6'd7, 1'b0, 1'b1, 64'h0, 3, 1'b1, init_data(7) ^ 64'h1, 1'b0);
      @(negedge clk); flip_req = 1'b1;
      @(negedge clk); flip_req = 1'b0;
      xact("par_ok7", 0, 6'd7, 1'b0, 1'b1, 64'h0, 3, 1'b0, init_data(7), 1'b0);
`endif

      check_vec("ack_count_final1", 64'(acks1), 64'(exp_acks1));
      check_vec("ack_count_final3", 64'(acks3), 64'(exp_acks3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
